// File: rtl/dense_frame_sequencer.sv
// Input-side sequencer for the dense layer: gathers a feature stream into a
// parallel vector, waits out the layer latency, then presents the captured result.
module dense_frame_sequencer #(
   parameter int unsigned WIDTH         = 5,
   parameter int unsigned INPUT_SIZE    = 32,
   parameter int unsigned OUTPUT_SIZE   = 1,
   parameter int unsigned LAYER_LATENCY = 9
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [WIDTH-1:0] in_data,
   input  logic                    in_valid,
   input  logic                    in_last,
   output logic                    in_ready,
   output logic signed [WIDTH-1:0] layer_data   [0:INPUT_SIZE-1],
   input  logic signed [WIDTH-1:0] layer_result [0:OUTPUT_SIZE-1],
   output logic signed [WIDTH-1:0] out_data     [0:OUTPUT_SIZE-1],
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    frame_err,
   output logic                    busy
);

   localparam int unsigned IDX_W  = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
   localparam int unsigned WAIT_W = $clog2(LAYER_LATENCY + 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(INPUT_SIZE - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LAYER_LATENCY - 1);

   typedef enum logic [1:0] {
      S_FILL    = 2'd0,
      S_WAIT    = 2'd1,
      S_PRESENT = 2'd2
   } state_t;

   state_t              state, state_n;
   logic [IDX_W-1:0]    idx, idx_n;
   logic [WAIT_W-1:0]   wait_cnt, wait_cnt_n;
   logic                wr_en;
   logic                capture;
   logic                err_n;

   // Next-state, index/counter update and framing-error detection
   always_comb begin
      state_n    = state;
      idx_n      = idx;
      wait_cnt_n = wait_cnt;
      wr_en      = 1'b0;
      capture    = 1'b0;
      err_n      = 1'b0;
      case (state)
         S_FILL: begin
            if (in_valid && in_ready) begin
               wr_en = 1'b1;
               if (idx == IDX_LAST) begin
                  idx_n      = '0;
                  wait_cnt_n = '0;
                  state_n    = S_WAIT;
                  err_n      = !in_last;
               end else if (in_last) begin
                  // Short frame: keep the written sample but restart the frame
                  idx_n = '0;
                  err_n = 1'b1;
               end else begin
                  idx_n = idx + IDX_W'(1);
               end
            end
         end
         S_WAIT: begin
            wait_cnt_n = wait_cnt + WAIT_W'(1);
            if (wait_cnt == WAIT_LAST) begin
               capture = 1'b1;
               state_n = S_PRESENT;
            end
         end
         S_PRESENT: begin
            if (out_valid && out_ready) begin
               state_n = S_FILL;
            end
         end
         default: begin
            state_n = S_FILL;
         end
      endcase
   end

   // Control registers; handshake flags are decoded from the next state so they stay registered
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= S_FILL;
         idx       <= '0;
         wait_cnt  <= '0;
         frame_err <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         idx       <= idx_n;
         wait_cnt  <= wait_cnt_n;
         frame_err <= err_n;
         in_ready  <= (state_n == S_FILL);
         out_valid <= (state_n == S_PRESENT);
         busy      <= (state_n != S_FILL);
      end
   end

   // Data path: vector writes only on fill handshakes, result captured once per frame
   always_ff @(posedge clk) begin
      if (!reset) begin
         layer_data <= '{default: '0};
         out_data   <= '{default: '0};
      end else begin
         if (wr_en) begin
            layer_data[idx] <= in_data;
         end
         if (capture) begin
            out_data <= layer_result;
         end
      end
   end

endmodule

// File: tb/tb_dense_frame_sequencer.sv
// Self-checking bench for dense_frame_sequencer: directed scenarios with literal
// expectations plus randomized traffic against a frame-level reference model.
module tb_dense_frame_sequencer;

   localparam int W   = 4;
   localparam int NIN = 7;
   localparam int NOUT = 5;
   localparam int LAT = 3;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic signed [W-1:0] in_data = '0;
   logic                in_valid = 1'b0;
   logic                in_last = 1'b0;
   logic                in_ready;
   logic signed [W-1:0] layer_data   [0:NIN-1];
   logic signed [W-1:0] layer_result [0:NOUT-1];
   logic signed [W-1:0] out_data     [0:NOUT-1];
   logic                out_valid;
   logic                out_ready = 1'b1;
   logic                frame_err;
   logic                busy;

   int checks = 0;
   int failures = 0;
   bit en = 1'b0;
   int n_valid = 0;
   int n_err = 0;
   int obs_out [0:NOUT-1];

   always #5 clk = ~clk;

   dense_frame_sequencer #(
      .WIDTH(W), .INPUT_SIZE(NIN), .OUTPUT_SIZE(NOUT), .LAYER_LATENCY(LAT)
   ) dut (
      .clk(clk), .reset(rst),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .layer_data(layer_data), .layer_result(layer_result),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .frame_err(frame_err), .busy(busy)
   );

   // Stub dense layer: three-stage delay line, result[j] = layer_data[j]
   logic signed [W-1:0] st1 [0:NOUT-1];
   logic signed [W-1:0] st2 [0:NOUT-1];
   logic signed [W-1:0] st3 [0:NOUT-1];
   always_ff @(posedge clk) begin
      for (int j = 0; j < NOUT; j++) begin
         st1[j] <= layer_data[j];
         st2[j] <= st1[j];
         st3[j] <= st2[j];
      end
   end
   assign layer_result = st3;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level reference: mode 0 collecting, 1 counting down the layer latency, 2 offering result
   int m_mode = 0;
   int m_fill = 0;
   int m_wait = 0;
   int m_layer [0:NIN-1];
   int m_out [0:NOUT-1];
   bit m_err = 1'b0;

   always @(posedge clk) begin
      if (!rst) begin
         m_mode = 0; m_fill = 0; m_wait = 0; m_err = 1'b0;
         for (int i = 0; i < NIN; i++) m_layer[i] = 0;
         for (int j = 0; j < NOUT; j++) m_out[j] = 0;
      end else begin
         m_err = 1'b0;
         if (m_mode == 0) begin
            if (in_valid) begin
               m_layer[m_fill] = int'(in_data);
               if (m_fill == NIN - 1) begin
                  m_fill = 0;
                  m_mode = 1;
                  m_wait = LAT;
                  m_err  = !in_last;
               end else if (in_last) begin
                  m_fill = 0;
                  m_err  = 1'b1;
               end else begin
                  m_fill++;
               end
            end
         end else if (m_mode == 1) begin
            m_wait--;
            if (m_wait == 0) begin
               for (int j = 0; j < NOUT; j++) m_out[j] = m_layer[j];
               m_mode = 2;
            end
         end else begin
            if (out_ready) m_mode = 0;
         end
      end
   end

   // Every-cycle comparison against the model, sampled on the falling edge
   always @(negedge clk) begin
      if (en) begin
         chk("in_ready", int'(in_ready), int'(m_mode == 0));
         chk("out_valid", int'(out_valid), int'(m_mode == 2));
         chk("busy", int'(busy), int'(m_mode != 0));
         chk("frame_err", int'(frame_err), int'(m_err));
         for (int j = 0; j < NOUT; j++)
            chk($sformatf("out_data[%0d]", j), int'(out_data[j]), m_out[j]);
         for (int i = 0; i < NIN; i++)
            chk($sformatf("layer_data[%0d]", i), int'(layer_data[i]), m_layer[i]);
         if (out_valid) begin
            n_valid++;
            for (int j = 0; j < NOUT; j++) obs_out[j] = int'(out_data[j]);
         end
         if (frame_err) n_err++;
      end
   end

   task automatic send(input int v, input bit last);
      bit acc;
      int k;
      in_valid = 1'b1;
      in_data  = W'(v);
      in_last  = last;
      k = 0;
      do begin
         acc = in_ready;
         @(negedge clk);
         k++;
      end while (!acc && k < 100);
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!acc) chk("send_timeout", 0, 1);
   endtask

   task automatic wait_valid();
      int k;
      k = 0;
      while (!out_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("wait_valid_timeout", int'(out_valid), 1);
   endtask

   task automatic send_ramp(input bit last7);
      for (int i = 1; i <= NIN; i++)
         send((i % 2 == 1) ? -i : i, (i == NIN) ? last7 : 1'b0);
   endtask

   int v0, e0;
   int rv [0:NIN-1];

   initial begin
      // Reset state
      rst = 1'b0;
      repeat (2) @(negedge clk);
      en  = 1'b1;
      rst = 1'b1;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      for (int j = 0; j < NOUT; j++) chk("rst_out_data", int'(out_data[j]), 0);
      for (int i = 0; i < NIN; i++) chk("rst_layer_data", int'(layer_data[i]), 0);

      // Back-to-back frame, downstream always ready
      out_ready = 1'b1;
      v0 = n_valid; e0 = n_err;
      send_ramp(1'b1);
      chk("t2_ready_low", int'(in_ready), 0);
      @(negedge clk);
      chk("t2_valid_e1", int'(out_valid), 0);
      @(negedge clk);
      chk("t2_valid_e2", int'(out_valid), 0);
      @(negedge clk);
      chk("t2_valid_e3", int'(out_valid), 1);
      @(negedge clk);
      chk("t2_valid_drop", int'(out_valid), 0);
      chk("t2_ready_back", int'(in_ready), 1);
      chk("t2_valid_count", n_valid - v0, 1);
      chk("t2_err_count", n_err - e0, 0);
      chk("t2_out0", obs_out[0], -1);
      chk("t2_out1", obs_out[1], 2);
      chk("t2_out2", obs_out[2], -3);
      chk("t2_out3", obs_out[3], 4);
      chk("t2_out4", obs_out[4], -5);

      // Backpressure: result held while out_ready low, pending upstream sample blocked
      out_ready = 1'b0;
      v0 = n_valid;
      send_ramp(1'b1);
      in_valid = 1'b1; in_data = W'(5); in_last = 1'b0;
      wait_valid();
      repeat (5) @(negedge clk);
      chk("t3_still_valid", int'(out_valid), 1);
      out_ready = 1'b1;
      @(negedge clk);
      chk("t3_valid_drop", int'(out_valid), 0);
      chk("t3_ready_back", int'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("t3_valid_count", n_valid - v0, 6);
      chk("t3_held_out0", obs_out[0], -1);
      chk("t3_held_out4", obs_out[4], -5);
      for (int i = 1; i < NIN; i++) send(5, i == NIN - 1);
      wait_valid();
      @(negedge clk);
      for (int j = 0; j < NOUT; j++) chk("t3_fives", obs_out[j], 5);

      // Early last, then a frame of ones
      e0 = n_err;
      send(2, 1'b0); send(3, 1'b0); send(4, 1'b1);
      @(negedge clk);
      chk("t4_err_pulse", n_err - e0, 1);
      for (int i = 0; i < NIN; i++) send(1, i == NIN - 1);
      wait_valid();
      @(negedge clk);
      chk("t4_err_total", n_err - e0, 1);
      for (int j = 0; j < NOUT; j++) chk("t4_ones", obs_out[j], 1);

      // Missing last: error reported, frame still processed
      e0 = n_err; v0 = n_valid;
      for (int i = 0; i < NIN; i++) begin
         rv[i] = $urandom_range(0, 15) - 8;
         send(rv[i], 1'b0);
      end
      wait_valid();
      @(negedge clk);
      chk("t5_err_pulse", n_err - e0, 1);
      chk("t5_valid_count", n_valid - v0, 1);
      for (int j = 0; j < NOUT; j++) chk("t5_out", obs_out[j], rv[j]);

      // Reset during WAIT discards the frame
      v0 = n_valid;
      send_ramp(1'b1);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("t6_ready", int'(in_ready), 1);
      chk("t6_busy", int'(busy), 0);
      for (int i = 0; i < NIN; i++) chk("t6_layer_zero", int'(layer_data[i]), 0);
      repeat (6) @(negedge clk);
      chk("t6_no_valid", n_valid - v0, 0);
      for (int i = 0; i < NIN; i++) send(i - 3, i == NIN - 1);
      wait_valid();
      @(negedge clk);
      for (int j = 0; j < NOUT; j++) chk("t6_new_frame", obs_out[j], j - 3);

      // Randomized traffic with occasional resets
      v0 = n_valid;
      repeat (3000) begin
         rst       = ($urandom_range(0, 199) != 0);
         in_valid  = ($urandom_range(0, 9) < 7);
         in_data   = W'($urandom);
         in_last   = ($urandom_range(0, 7) == 0);
         out_ready = ($urandom_range(0, 1) == 1);
         @(negedge clk);
      end
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      repeat (20) @(negedge clk);
      chk("rand_saw_results", int'(n_valid - v0 > 20), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
